// File: rtl/mem_dram_timing.sv
// DRAM timing controller: single-word req/ack access to row/column address, bank selects, RAS/CAS, plus CBR refresh.
// All outputs registered from the next state; ack lands in the last CAS cycle; req is ignored (held off) while busy.
module mem_dram_timing #(
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 3,
  parameter int T_RP         = 3,
  parameter int REF_INTERVAL = 780
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  output logic        ack,
  output logic        err,
  output logic        rd_strobe,
  output logic        busy,
  output logic [9:0]  AA_9_0,
  output logic        BANK0,
  output logic        BANK1,
  output logic        BANK2,
  output logic        RAS,
  output logic        CAS,
  output logic        MWRITE50_n,
  output logic        ref_miss
);

  typedef enum logic [2:0] {IDLE, ROW, COL, PRE, REF_CAS, REF_RAS} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_pending_q, ref_pending_d;
  logic        ref_miss_q, ref_miss_d;
  logic [1:0]  bank_q, bank_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [9:0]  aa_q, aa_d;
  logic [2:0]  bank_sel_q, bank_sel_d;
  logic        ras_q, ras_d;
  logic        cas_q, cas_d;
  logic        mwn_q, mwn_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        enter_ref;
  logic        bad_bank;
  logic        expire;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = we_q;
    enter_ref = 1'b0;
    bad_bank  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          state_d   = REF_CAS;
          cnt_d     = 16'd0;
          enter_ref = 1'b1;
        end else if (req) begin
          bank_d = addr[21:20];
          row_d  = addr[19:10];
          col_d  = addr[9:0];
          we_d   = we;
          if (addr[21:20] == 2'd3) begin
            state_d  = PRE;
            cnt_d    = 16'(T_RP - 1);
            bad_bank = 1'b1;
          end else begin
            state_d = ROW;
            cnt_d   = 16'(T_RCD - 1);
          end
        end
      end
      ROW: begin
        if (cnt_q == 16'd0) begin
          state_d = COL;
          cnt_d   = 16'(T_CAS - 1);
        end else cnt_d = cnt_q - 16'd1;
      end
      COL: begin
        if (cnt_q == 16'd0) begin
          state_d = PRE;
          cnt_d   = 16'(T_RP - 1);
        end else cnt_d = cnt_q - 16'd1;
      end
      PRE: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else cnt_d = cnt_q - 16'd1;
      end
      REF_CAS: begin
        state_d = REF_RAS;
        cnt_d   = 16'(T_RCD + T_CAS - 1);
      end
      REF_RAS: begin
        if (cnt_q == 16'd0) begin
          state_d = PRE;
          cnt_d   = 16'(T_RP - 1);
        end else cnt_d = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // A new expiry wins over the clear on REF_CAS entry; only an unserviced one counts as a miss.
    expire        = (ref_cnt_q == 16'd0);
    ref_cnt_d     = expire ? 16'(REF_INTERVAL - 1) : ref_cnt_q - 16'd1;
    ref_pending_d = expire | (ref_pending_q & ~enter_ref);
    ref_miss_d    = ref_miss_q | (expire & ref_pending_q & ~enter_ref);

    aa_d       = 10'd0;
    bank_sel_d = 3'b000;
    ras_d      = 1'b0;
    cas_d      = 1'b0;
    mwn_d      = 1'b1;
    case (state_d)
      ROW: begin
        aa_d       = row_d;
        bank_sel_d = 3'b001 << bank_d;
        ras_d      = 1'b1;
      end
      COL: begin
        aa_d       = col_d;
        bank_sel_d = 3'b001 << bank_d;
        ras_d      = 1'b1;
        cas_d      = 1'b1;
        mwn_d      = ~we_d;
      end
      REF_CAS: begin
        bank_sel_d = 3'b111;
        cas_d      = 1'b1;
      end
      REF_RAS: begin
        bank_sel_d = 3'b111;
        ras_d      = 1'b1;
        cas_d      = 1'b1;
      end
      default: ;
    endcase
    ack_d  = bad_bank | (state_d == COL && cnt_d == 16'd0);
    rd_d   = (state_d == COL && cnt_d == 16'd0) & ~we_d;
    err_d  = bad_bank;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      ref_cnt_q     <= 16'(REF_INTERVAL - 1);
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
      bank_q        <= 2'd0;
      row_q         <= 10'd0;
      col_q         <= 10'd0;
      we_q          <= 1'b0;
      aa_q          <= 10'd0;
      bank_sel_q    <= 3'b000;
      ras_q         <= 1'b0;
      cas_q         <= 1'b0;
      mwn_q         <= 1'b1;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rd_q          <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      we_q          <= we_d;
      aa_q          <= aa_d;
      bank_sel_q    <= bank_sel_d;
      ras_q         <= ras_d;
      cas_q         <= cas_d;
      mwn_q         <= mwn_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rd_q          <= rd_d;
      busy_q        <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign rd_strobe  = rd_q;
  assign busy       = busy_q;
  assign AA_9_0     = aa_q;
  assign BANK0      = bank_sel_q[0];
  assign BANK1      = bank_sel_q[1];
  assign BANK2      = bank_sel_q[2];
  assign RAS        = ras_q;
  assign CAS        = cas_q;
  assign MWRITE50_n = mwn_q;
  assign ref_miss   = ref_miss_q;

endmodule

// File: tb/tb_mem_dram_timing.sv
// Bench for mem_dram_timing: u0 uses default timing, u1 uses REF_INTERVAL=20 for refresh and reset-abort cases.
// Expected per-cycle outputs and acks are queued by the stimulus; monitors compare on the falling edge.
module tb_mem_dram_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9:0] aa;
    logic [2:0] bank;
    logic ras, cas, mwn, ack, err, rd, busy, miss;
  } vec_t;
  typedef struct { int cyc; vec_t v; } tr_t;
  typedef struct { int cyc; logic err; logic rd; } ak_t;

  tr_t tq0[$], tq1[$];
  ak_t aq0[$], aq1[$];
  int  n_vec = 0, n_err = 0;
  bit  chk0 = 0, chk1 = 0;

  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [21:0] addr0 = '0, addr1 = '0;
  logic        ack0, err0, rd0, busy0, b0_0, b1_0, b2_0, ras0, cas0, mwn0, miss0;
  logic        ack1, err1, rd1, busy1, b0_1, b1_1, b2_1, ras1, cas1, mwn1, miss1;
  logic [9:0]  aa0, aa1;
  vec_t        act0, act1;

  mem_dram_timing u0 (
    .sysclk(clk), .sys_rst(rst0), .req(req0), .we(we0), .addr(addr0),
    .ack(ack0), .err(err0), .rd_strobe(rd0), .busy(busy0), .AA_9_0(aa0),
    .BANK0(b0_0), .BANK1(b1_0), .BANK2(b2_0), .RAS(ras0), .CAS(cas0),
    .MWRITE50_n(mwn0), .ref_miss(miss0)
  );

  mem_dram_timing #(.REF_INTERVAL(20)) u1 (
    .sysclk(clk), .sys_rst(rst1), .req(req1), .we(we1), .addr(addr1),
    .ack(ack1), .err(err1), .rd_strobe(rd1), .busy(busy1), .AA_9_0(aa1),
    .BANK0(b0_1), .BANK1(b1_1), .BANK2(b2_1), .RAS(ras1), .CAS(cas1),
    .MWRITE50_n(mwn1), .ref_miss(miss1)
  );

  assign act0 = {aa0, b2_0, b1_0, b0_0, ras0, cas0, mwn0, ack0, err0, rd0, busy0, miss0};
  assign act1 = {aa1, b2_1, b1_1, b0_1, ras1, cas1, mwn1, ack1, err1, rd1, busy1, miss1};

  function automatic vec_t mkv(input logic [9:0] aa, input logic [2:0] bank,
                               input logic ras, cas, mwn, ack, err, rd, busy);
    vec_t v;
    v.aa = aa; v.bank = bank; v.ras = ras; v.cas = cas; v.mwn = mwn;
    v.ack = ack; v.err = err; v.rd = rd; v.busy = busy; v.miss = 1'b0;
    return v;
  endfunction

  task automatic push_tr(input int which, input int c, input vec_t v);
    tr_t t;
    t.cyc = c; t.v = v;
    if (which == 0) tq0.push_back(t); else tq1.push_back(t);
  endtask

  task automatic push_ak(input int which, input int c, input logic e, input logic r);
    ak_t a;
    a.cyc = c; a.err = e; a.rd = r;
    if (which == 0) aq0.push_back(a); else aq1.push_back(a);
  endtask

  // Hand-written default timing: ROW 2, COL 3, PRE 3; cycle k after acceptance edge n is sampled at cyc n+k-1.
  task automatic push_access(input int which, input int n, input logic [1:0] b,
                             input logic [9:0] row, col, input logic w, input int ncyc);
    logic [2:0] oh;
    oh = 3'b001 << b;
    if (b == 2'd3) begin
      for (int k = 1; k <= 3 && k <= ncyc; k++)
        push_tr(which, n + k - 1, mkv(10'd0, 3'b000, 0, 0, 1, k == 1, k == 1, 0, 1));
      if (ncyc >= 1) push_ak(which, n, 1'b1, 1'b0);
    end else begin
      for (int k = 1; k <= ncyc; k++) begin
        if (k <= 2)      push_tr(which, n + k - 1, mkv(row, oh, 1, 0, 1, 0, 0, 0, 1));
        else if (k <= 5) push_tr(which, n + k - 1, mkv(col, oh, 1, 1, ~w, k == 5, 0, (k == 5) & ~w, 1));
        else             push_tr(which, n + k - 1, mkv(10'd0, 3'b000, 0, 0, 1, 0, 0, 0, 1));
      end
      if (ncyc >= 5) push_ak(which, n + 4, 1'b0, ~w);
    end
  endtask

  task automatic push_ref(input int which, input int r);
    push_tr(which, r, mkv(10'd0, 3'b111, 0, 1, 1, 0, 0, 0, 1));
    for (int k = 1; k <= 5; k++) push_tr(which, r + k, mkv(10'd0, 3'b111, 1, 1, 1, 0, 0, 0, 1));
    for (int k = 6; k <= 8; k++) push_tr(which, r + k, mkv(10'd0, 3'b000, 0, 0, 1, 0, 0, 0, 1));
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic r, input logic w, input logic [21:0] a);
    if (which == 0) begin req0 = r; we0 = w; addr0 = a; end
    else begin req1 = r; we1 = w; addr1 = a; end
  endtask

  // Issue a request expected to be accepted on edge n; addr/we are scrambled right after acceptance.
  task automatic do_access(input int which, input int n, input logic [1:0] b,
                           input logic [9:0] row, col, input logic w);
    drive(which, 1'b1, w, {b, row, col});
    push_access(which, n, b, row, col, w, 8);
    wait_cyc(n);
    drive(which, 1'b1, ~w, ~{b, row, col});
    if (b == 2'd3) begin
      drive(which, 1'b0, 1'b0, 22'd0);
      wait_cyc(n + 3);
    end else begin
      wait_cyc(n + 4);
      drive(which, 1'b0, 1'b0, 22'd0);
      wait_cyc(n + 8);
    end
  endtask

  task automatic check_dut(input int which, input vec_t act);
    vec_t exp;
    tr_t  t;
    ak_t  a;
    bit   have_a;
    exp = mkv(10'd0, 3'b000, 0, 0, 1, 0, 0, 0, 0);
    if (which == 0 && tq0.size() > 0 && tq0[0].cyc == cyc) begin t = tq0.pop_front(); exp = t.v; end
    if (which == 1 && tq1.size() > 0 && tq1[0].cyc == cyc) begin t = tq1.pop_front(); exp = t.v; end
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL trace%0d cyc=%0d got=%h want=%h", which, cyc, act, exp);
    end
    if (act.ack === 1'b1) begin
      n_vec++;
      have_a = 0;
      if (which == 0 && aq0.size() > 0) begin a = aq0.pop_front(); have_a = 1; end
      if (which == 1 && aq1.size() > 0) begin a = aq1.pop_front(); have_a = 1; end
      if (!have_a) begin
        n_err++;
        $display("FAIL ack%0d unexpected at cyc=%0d", which, cyc);
      end else if (a.cyc != cyc || a.err !== act.err || a.rd !== act.rd) begin
        n_err++;
        $display("FAIL ack%0d got cyc=%0d err=%b rd=%b want cyc=%0d err=%b rd=%b",
                 which, cyc, act.err, act.rd, a.cyc, a.err, a.rd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk0) check_dut(0, act0);
    if (chk1) check_dut(1, act1);
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int p0, p1;
  initial begin
    @(posedge clk);
    #1;
    chk0 = 1; chk1 = 1;
    wait_cyc(3);
    rst0 = 1'b0; rst1 = 1'b0;
    p0 = 3;
    fork
      begin
        wait_cyc(p0 + 2);
        do_access(0, cyc + 1, 2'd1, 10'h155, 10'h2AA, 1'b0);
        do_access(0, cyc + 1, 2'd2, 10'h2A5, 10'h3FF, 1'b1);
        do_access(0, cyc + 1, 2'd3, 10'h0F0, 10'h00F, 1'b1);
        do_access(0, cyc + 1, 2'd0, 10'h3FF, 10'h000, 1'b0);
        do_access(0, cyc + 1, 2'd1, 10'h000, 10'h155, 1'b1);
        wait_cyc(cyc + 3);
      end
      begin
        push_ref(1, p0 + 21);
        push_ref(1, p0 + 41);
        // req rises in the cycle ref_pending is set: refresh first, accepted at p0+51, ack 15 cycles on
        wait_cyc(p0 + 40);
        do_access(1, p0 + 51, 2'd0, 10'h0AB, 10'h123, 1'b0);
        push_ref(1, p0 + 61);
        wait_cyc(p0 + 70);
        drive(1, 1'b1, 1'b0, {2'd2, 10'h011, 10'h022});
        push_access(1, p0 + 71, 2'd2, 10'h011, 10'h022, 1'b0, 4);
        wait_cyc(p0 + 74);
        rst1 = 1'b1;
        wait_cyc(p0 + 75);
        rst1 = 1'b0;
        drive(1, 1'b0, 1'b0, 22'd0);
        p1 = p0 + 75;
        push_ref(1, p1 + 21);
        push_ref(1, p1 + 41);
        wait_cyc(p1 + 52);
      end
    join
    chk0 = 0; chk1 = 0;
    n_vec++;
    if (aq0.size() != 0 || aq1.size() != 0) begin
      n_err++;
      $display("FAIL acks_outstanding got %0d/%0d want 0/0", aq0.size(), aq1.size());
    end
    n_vec++;
    if (tq0.size() != 0 || tq1.size() != 0) begin
      n_err++;
      $display("FAIL trace_outstanding got %0d/%0d want 0/0", tq0.size(), tq1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
